// File: rtl/iir_pkg.sv
// Shared definitions for the IIR filter output sink: default sample width,
// sink FSM state encoding and a constant-foldable ceil(log2) helper.
package iir_pkg;

    localparam int NB_DEF = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } sink_state_e;

    // ceil(log2(value)), usable in parameter and port width expressions
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read port (1-cycle read latency) and
// extra-MSB pointers for full/empty discrimination.
module sync_fifo
    import iir_pkg::*;
#(
    parameter int W     = 13,
    parameter int DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [W-1:0]          wr_data,
    input  logic                  rd_en,
    output logic [W-1:0]          rd_data,
    output logic                  rd_valid,
    output logic [clog2(DEPTH):0] count,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] count_r;
    logic [W-1:0]  rd_data_r;
    logic          rd_valid_r;
    logic          full_s;
    logic          empty_s;
    logic          do_wr_s;
    logic          do_rd_s;

    // Full/empty from pointers; a write into a full FIFO only succeeds alongside a pop
    always_comb begin
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        do_rd_s = rd_en && !empty_s;
        do_wr_s = wr_en && (!full_s || do_rd_s);
    end

    // Storage, pointers, occupancy and the registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {PW{1'b0}};
            rd_data_r  <= {W{1'b0}};
            rd_valid_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else begin
            if (do_wr_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
                wr_ptr_r                <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_rd_s) begin
                rd_data_r <= mem_r[rd_ptr_r[AW-1:0]];
                rd_ptr_r  <= rd_ptr_r + PW'(1);
            end else begin
                rd_data_r <= rd_data_r;
                rd_ptr_r  <= rd_ptr_r;
            end
            rd_valid_r <= do_rd_s;
            case ({do_wr_s, do_rd_s})
                2'b10:   count_r <= count_r + PW'(1);
                2'b01:   count_r <= count_r - PW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign count    = count_r;
    assign full     = full_s;
    assign empty    = empty_s;

endmodule

// File: rtl/iir_sample_sink.sv
// Receive end of the IIR filter stream: buffers samples, counts a frame and
// flags overflow/completion. Optional saturation statistics: IIR_SINK_SAT_STATS_EN.
module iir_sample_sink
    import iir_pkg::*;
#(
    parameter int NB        = NB_DEF,
    parameter int DEPTH     = 16,
    parameter int N_SAMPLES = 256,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  vIn,
    input  logic [NB:0]           dIn,
    input  logic                  rd_en,
    output logic [NB:0]           rd_data,
    output logic                  rd_valid,
    output logic [clog2(DEPTH):0] fifo_count,
    output logic [CNT_W-1:0]      sample_cnt,
    output logic                  overflow,
    output logic                  done
`ifdef IIR_SINK_SAT_STATS_EN
    ,
    output logic [CNT_W-1:0]      sat_cnt
`endif
);

    localparam int CW = clog2(DEPTH) + 1;

    sink_state_e          state_r;
    logic [CNT_W-1:0]     sample_cnt_r;
    logic                 overflow_r;
    logic                 done_r;
    logic [CW-1:0]        fifo_count_s;
    logic                 full_s;
    logic                 empty_s;
    logic                 wr_en_s;
    logic                 pop_s;
    logic [CNT_W-1:0]     cnt_next_s;
    logic                 last_s;
    logic                 drained_s;

    sync_fifo #(
        .W     (NB + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en_s),
        .wr_data  (dIn),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (fifo_count_s),
        .full     (full_s),
        .empty    (empty_s)
    );

    // Drained means occupancy is zero after this edge (no writes happen in DRAIN)
    always_comb begin
        wr_en_s    = (state_r == COLLECT) && vIn;
        pop_s      = rd_en && !empty_s;
        cnt_next_s = sample_cnt_r + CNT_W'(1);
        last_s     = (cnt_next_s == CNT_W'(N_SAMPLES));
        drained_s  = (fifo_count_s == CW'(0)) ||
                     ((fifo_count_s == CW'(1)) && pop_s);
    end

    // Frame FSM with sample counter, sticky overflow and done flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            sample_cnt_r <= {CNT_W{1'b0}};
            overflow_r   <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r      <= COLLECT;
                        sample_cnt_r <= {CNT_W{1'b0}};
                        overflow_r   <= 1'b0;
                        done_r       <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                COLLECT: begin
                    if (vIn) begin
                        sample_cnt_r <= cnt_next_s;
                        if (full_s && !pop_s) begin
                            overflow_r <= 1'b1;
                        end else begin
                            overflow_r <= overflow_r;
                        end
                        if (last_s) begin
                            state_r <= DRAIN;
                        end else begin
                            state_r <= COLLECT;
                        end
                    end else begin
                        state_r <= COLLECT;
                    end
                end
                DRAIN: begin
                    if (drained_s) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef IIR_SINK_SAT_STATS_EN
    localparam logic [NB:0] SAT_MIN = {1'b1, {NB{1'b0}}};
    localparam logic [NB:0] SAT_MAX = {1'b0, {NB{1'b1}}};

    logic [CNT_W-1:0] sat_cnt_r;
    logic             is_sat_s;

    // Rail detection on the incoming sample, regardless of whether it is stored
    always_comb begin
        is_sat_s = (dIn == SAT_MIN) || (dIn == SAT_MAX);
    end

    // Saturating count of railed samples within the current frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_r <= {CNT_W{1'b0}};
        end else if (((state_r == IDLE) || (state_r == DONE)) && start) begin
            sat_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == COLLECT) && vIn && is_sat_s &&
                     (sat_cnt_r != {CNT_W{1'b1}})) begin
            sat_cnt_r <= sat_cnt_r + CNT_W'(1);
        end else begin
            sat_cnt_r <= sat_cnt_r;
        end
    end

    assign sat_cnt = sat_cnt_r;
`endif

    assign fifo_count = fifo_count_s;
    assign sample_cnt = sample_cnt_r;
    assign overflow   = overflow_r;
    assign done       = done_r;

endmodule

// File: tb/tb_iir_sample_sink.sv
// Directed bench for iir_sample_sink: instance B (N_SAMPLES=256) for buffering,
// overflow and reset scenarios, instance A (N_SAMPLES=8) for frame completion.
module tb_iir_sample_sink;

    logic        clk;
    logic        rst_n;
    int          tests;
    int          fails;

    logic        a_start, a_vin, a_rd_en;
    logic [12:0] a_din, a_rd_data;
    logic        a_rd_valid, a_overflow, a_done;
    logic [4:0]  a_fifo_count;
    logic [15:0] a_sample_cnt;

    logic        b_start, b_vin, b_rd_en;
    logic [12:0] b_din, b_rd_data;
    logic        b_rd_valid, b_overflow, b_done;
    logic [4:0]  b_fifo_count;
    logic [15:0] b_sample_cnt;
`ifdef IIR_SINK_SAT_STATS_EN
    logic [15:0] a_sat_cnt, b_sat_cnt;
`endif

    iir_sample_sink #(.NB(12), .DEPTH(16), .N_SAMPLES(8), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .vIn(a_vin), .dIn(a_din),
        .rd_en(a_rd_en), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
        .fifo_count(a_fifo_count), .sample_cnt(a_sample_cnt),
        .overflow(a_overflow), .done(a_done)
`ifdef IIR_SINK_SAT_STATS_EN
        , .sat_cnt(a_sat_cnt)
`endif
    );

    iir_sample_sink #(.NB(12), .DEPTH(16), .N_SAMPLES(256), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .vIn(b_vin), .dIn(b_din),
        .rd_en(b_rd_en), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .fifo_count(b_fifo_count), .sample_cnt(b_sample_cnt),
        .overflow(b_overflow), .done(b_done)
`ifdef IIR_SINK_SAT_STATS_EN
        , .sat_cnt(b_sat_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic b_start_frame();
        b_start = 1'b1;
        step();
        b_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        chk("reset_rd_data", b_rd_data, 0);
        chk("reset_rd_valid", b_rd_valid, 0);
        chk("reset_fifo_count", b_fifo_count, 0);
        chk("reset_sample_cnt", b_sample_cnt, 0);
        chk("reset_overflow", b_overflow, 0);
        chk("reset_done", b_done, 0);
`ifdef IIR_SINK_SAT_STATS_EN
        chk("reset_sat_cnt", b_sat_cnt, 0);
`endif
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        b_start_frame();
        for (int i = 1; i <= 4; i++) begin
            b_vin = 1'b1;
            b_din = 13'(i);
            step();
        end
        b_vin = 1'b0;
        chk("basic_count", b_fifo_count, 4);
        chk("basic_sample_cnt", b_sample_cnt, 4);
        chk("basic_no_valid_before_read", b_rd_valid, 0);
        for (int i = 1; i <= 4; i++) begin
            b_rd_en = 1'b1;
            step();
            chk("basic_rd_valid", b_rd_valid, 1);
            chk("basic_rd_data", b_rd_data, i);
        end
        b_rd_en = 1'b0;
        step();
        chk("basic_valid_drops", b_rd_valid, 0);
        chk("basic_count_zero", b_fifo_count, 0);
    endtask

    task automatic test_drain();
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a_vin = 1'b1;
            a_din = 13'(10 + i);
            step();
        end
        chk("drain_sample_cnt", a_sample_cnt, 8);
        chk("drain_count", a_fifo_count, 8);
        a_din = 13'd99;
        step();
        a_vin = 1'b0;
        chk("drain_9th_ignored_cnt", a_sample_cnt, 8);
        chk("drain_9th_ignored_fifo", a_fifo_count, 8);
        for (int i = 0; i < 8; i++) begin
            a_rd_en = 1'b1;
            step();
            chk("drain_rd_data", a_rd_data, 10 + i);
            chk("drain_done", a_done, (i == 7) ? 1 : 0);
        end
        a_rd_en = 1'b0;
        chk("drain_final_count", a_fifo_count, 0);
        chk("drain_no_overflow", a_overflow, 0);
    endtask

    task automatic test_overflow();
        pulse_reset();
        b_start_frame();
        for (int i = 0; i < 18; i++) begin
            b_vin = 1'b1;
            b_din = 13'(100 + i);
            step();
        end
        b_vin = 1'b0;
        chk("ovf_count", b_fifo_count, 16);
        chk("ovf_flag", b_overflow, 1);
        chk("ovf_sample_cnt", b_sample_cnt, 18);
        for (int i = 0; i < 16; i++) begin
            b_rd_en = 1'b1;
            step();
            chk("ovf_order", b_rd_data, 100 + i);
        end
        b_rd_en = 1'b0;
        chk("ovf_drained", b_fifo_count, 0);
    endtask

    task automatic test_simultaneous();
        pulse_reset();
        b_start_frame();
        for (int i = 0; i < 16; i++) begin
            b_vin = 1'b1;
            b_din = 13'(i);
            step();
        end
        b_din = 13'd50;
        b_rd_en = 1'b1;
        step();
        chk("sim_full_overflow", b_overflow, 0);
        chk("sim_full_count", b_fifo_count, 16);
        chk("sim_full_rd_data", b_rd_data, 0);
        b_vin = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
        end
        b_rd_en = 1'b0;
        chk("sim_full_last_data", b_rd_data, 50);
        chk("sim_emptied", b_fifo_count, 0);
        b_vin = 1'b1;
        b_din = 13'd77;
        b_rd_en = 1'b1;
        step();
        b_vin = 1'b0;
        b_rd_en = 1'b0;
        chk("sim_empty_rd_valid", b_rd_valid, 0);
        chk("sim_empty_count", b_fifo_count, 1);
        chk("sim_empty_hold", b_rd_data, 50);
    endtask

    task automatic test_async_reset();
        pulse_reset();
        b_start_frame();
        for (int i = 0; i < 5; i++) begin
            b_vin = 1'b1;
            b_din = 13'(20 + i);
            step();
        end
        b_vin = 1'b0;
        b_rd_en = 1'b1;
        step();
        b_rd_en = 1'b0;
        chk("areset_pre_count", b_fifo_count, 4);
        #1;
        rst_n = 1'b0;
        #1;
        chk("areset_count", b_fifo_count, 0);
        chk("areset_sample_cnt", b_sample_cnt, 0);
        chk("areset_rd_data", b_rd_data, 0);
        chk("areset_rd_valid", b_rd_valid, 0);
        rst_n = 1'b1;
        step();
        b_start_frame();
        b_vin = 1'b1;
        b_din = 13'd9;
        step();
        b_vin = 1'b0;
        b_rd_en = 1'b1;
        step();
        b_rd_en = 1'b0;
        chk("areset_restart_data", b_rd_data, 9);
        chk("areset_restart_cnt", b_sample_cnt, 1);
    endtask

`ifdef IIR_SINK_SAT_STATS_EN
    task automatic test_sat_stats();
        logic [12:0] vec [4];
        vec[0] = 13'h1000;
        vec[1] = 13'h0FFF;
        vec[2] = 13'h0000;
        vec[3] = 13'h0FFF;
        pulse_reset();
        b_start_frame();
        for (int i = 0; i < 4; i++) begin
            b_vin = 1'b1;
            b_din = vec[i];
            step();
        end
        b_vin = 1'b0;
        chk("sat_cnt", b_sat_cnt, 3);
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        a_start = 1'b0; a_vin = 1'b0; a_din = 13'd0; a_rd_en = 1'b0;
        b_start = 1'b0; b_vin = 1'b0; b_din = 13'd0; b_rd_en = 1'b0;
        test_reset();
        test_basic();
        test_drain();
        test_overflow();
        test_simultaneous();
        test_async_reset();
`ifdef IIR_SINK_SAT_STATS_EN
        test_sat_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
